alu_req_scheduler: RTL and testbench

// - Shares one 4-bit mini-ALU datapath (add/sub/shl/shr, 20-bit result) between NREQ requesters.
// - Round-robin arbitration; valid/ready on the request and response sides.
// - Registers operands and result; the result feeds the display encoder.
// - Sits between the input sources (switches, UART, test sequencer) and the result/display path.

---
 rtl/alu_ctrl_pkg.sv | 24 ++
 rtl/alu_core.sv | 34 +++
 rtl/alu_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_alu_req_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU request scheduler.
//   alu_op_e      : ALU operation, encoded as {ope, sign}
//   sched_state_e : scheduler FSM states
//   to_alu_op()   : maps the request-side {ope, sign} bits onto alu_op_e
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } sched_state_e;

  function automatic alu_op_e to_alu_op(input logic ope, input logic sign);
    return alu_op_e'({ope, sign});
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational mini-ALU. Operands are unsigned and zero-extended to RES_W.
//   op1, op2 : operands (op2 is the shift amount for shifts)
//   op       : add / sub (two's-complement wrap) / logical shl / logical shr
//   result   : RES_W-bit result
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W  = 4,
  parameter int RES_W = 20
) (
  input  logic [OP_W-1:0]  op1,
  input  logic [OP_W-1:0]  op2,
  input  alu_op_e          op,
  output logic [RES_W-1:0] result
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  always_comb begin
    a_ext  = RES_W'(op1);
    b_ext  = RES_W'(op2);
    result = '0;
    case (op)
      OP_ADD:  result = a_ext + b_ext;
      // Subtraction at full RES_W width wraps naturally modulo 2^RES_W.
      OP_SUB:  result = a_ext - b_ext;
      OP_SHL:  result = a_ext << op2;
      OP_SHR:  result = a_ext >> op2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one mini-ALU between NREQ requesters with round-robin arbitration.
// One operation in flight at a time: IDLE (accept) -> EXEC (compute) -> RESP (hold
// result until consumed).
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake; req_ready is one-hot or zero
//   req_op1/req_op2       : packed operands, requester i at [i*OP_W +: OP_W]
//   req_ope/req_sign      : operation select per requester
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_id       : registered result and the requester it belongs to
//   busy                  : high outside IDLE
//   ops_done              : saturating count of completed responses
module alu_req_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int OP_W  = 4,
  parameter int RES_W = 20,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*OP_W-1:0]    req_op1,
  input  logic [NREQ*OP_W-1:0]    req_op2,
  input  logic [NREQ-1:0]         req_ope,
  input  logic [NREQ-1:0]         req_sign,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        ops_done
);

  localparam int IDW = $clog2(NREQ);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sched_state_e     state;
  sched_state_e     state_nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_nxt;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   cand;
  logic             grant_vld;
  logic             latch_en;
  logic             exec_en;
  logic             done_en;

  logic [OP_W-1:0]  op1_p0;
  logic [OP_W-1:0]  op2_p0;
  alu_op_e          op_p0;
  logic [IDW-1:0]   id_p0;
  logic [RES_W-1:0] alu_res;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  // The requester after the one just served gets first look next time.
  always_comb begin
    ptr_nxt = (id_p0 == IDW'(NREQ - 1)) ? '0 : id_p0 + IDW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // req_ready is gated by rst_n so it reads zero while reset is held, even
  // though the FSM sits in IDLE then.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    latch_en  = 1'b0;
    exec_en   = 1'b0;
    done_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_vld && rst_n) begin
          req_ready[grant] = 1'b1;
          latch_en         = 1'b1;
          state_nxt        = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en   = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done_en   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- stage p0: operand capture on request handshake ----
  always_ff @(posedge clk) begin
    if (latch_en) begin
      op1_p0 <= req_op1[int'(grant)*OP_W +: OP_W];
      op2_p0 <= req_op2[int'(grant)*OP_W +: OP_W];
      op_p0  <= to_alu_op(req_ope[grant], req_sign[grant]);
      id_p0  <= grant;
    end
  end

  alu_core #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_alu (
    .op1    (op1_p0),
    .op2    (op2_p0),
    .op     (op_p0),
    .result (alu_res)
  );

  // ---- stage p1: result register, held until consumed ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (exec_en) begin
      rsp_data <= alu_res;
      rsp_id   <= id_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      ops_done <= '0;
    end else if (done_en) begin
      ptr      <= ptr_nxt;
      ops_done <= sat_inc(ops_done);
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;

  localparam int NREQ  = 2;
  localparam int OP_W  = 4;
  localparam int RES_W = 20;
  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready, req_ready2;
  logic [NREQ*OP_W-1:0]    req_op1, req_op2;
  logic [NREQ-1:0]         req_ope, req_sign;
  logic                    rsp_valid, rsp_valid2;
  logic                    rsp_ready;
  logic [RES_W-1:0]        rsp_data, rsp_data2;
  logic [$clog2(NREQ)-1:0] rsp_id, rsp_id2;
  logic                    busy, busy2;
  logic [CNT_W-1:0]        ops_done;
  logic [1:0]              ops_done2;

  logic            v [NREQ];
  logic [OP_W-1:0] a [NREQ];
  logic [OP_W-1:0] b [NREQ];
  logic            e [NREQ];
  logic            s [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_ope   = '0;
    req_sign  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = v[i];
      req_op1[i*OP_W +: OP_W] = a[i];
      req_op2[i*OP_W +: OP_W] = b[i];
      req_ope[i]             = e[i];
      req_sign[i]            = s[i];
    end
  end

  alu_req_scheduler #(.NREQ(NREQ), .OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ope(req_ope), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .ops_done(ops_done)
  );

  alu_req_scheduler #(.NREQ(NREQ), .OP_W(OP_W), .RES_W(RES_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_op1(req_op1), .req_op2(req_op2), .req_ope(req_ope), .req_sign(req_sign),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_id(rsp_id2),
    .busy(busy2), .ops_done(ops_done2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic logic [RES_W-1:0] ref_alu(input int x, input int y, input bit ope, input bit sign);
    int r;
    if (!ope) r = sign ? (x - y) : (x + y);
    else      r = sign ? (x >> y) : (x << y);
    return r[RES_W-1:0];
  endfunction

  function automatic int pick(input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct {
    int               id;
    logic [RES_W-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   acc[$];

  // Reference model: one op in flight, response 2 cycles after accept.
  int             m_ptr = 0, m_age = 0, m_gid = 0, m_done = 0, m_g;
  bit             m_busy = 0, m_ev;
  logic [NREQ-1:0] m_er;

  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_ptr = 0; m_busy = 0; m_age = 0; m_done = 0;
    end else begin
      if (m_busy) m_age++;
      m_g  = m_busy ? -1 : pick(m_ptr);
      m_er = '0;
      if (m_g >= 0) m_er[m_g] = 1'b1;
      m_ev = m_busy && (m_age >= 2);
      chk("req_ready", req_ready, m_er);
      chk("req_ready_sat", req_ready2, m_er);
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      chk("rsp_valid", rsp_valid, m_ev);
      chk("rsp_valid_sat", rsp_valid2, m_ev);
      chk("busy", busy, m_busy);
      chk("busy_sat", busy2, m_busy);
      chk("ops_done", ops_done, m_done);
      chk("ops_done_sat", ops_done2, (m_done > 3) ? 3 : m_done);
      if (m_g >= 0) begin
        sbq.push_back('{m_g, ref_alu(a[m_g], b[m_g], e[m_g], s[m_g])});
        m_busy = 1; m_age = 0; m_gid = m_g;
      end else if (m_ev && rsp_ready) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % NREQ;
        m_done++;
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake.
  bit               hold = 0;
  logic [RES_W-1:0] hdata;
  logic [31:0]      hid;
  exp_t             mx;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
    end else if (rsp_valid) begin
      if (hold) begin
        chk("hold_data", rsp_data, hdata);
        chk("hold_id", rsp_id, hid);
      end
      if (rsp_ready) begin
        hold = 0;
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: got data 0x%0h id %0d with nothing outstanding", rsp_data, rsp_id);
        end else begin
          mx = sbq.pop_front();
          chk("rsp_data", rsp_data, mx.data);
          chk("rsp_id", rsp_id, mx.id);
          chk("rsp_data_sat", rsp_data2, mx.data);
          chk("rsp_id_sat", rsp_id2, mx.id);
        end
      end else begin
        hold  = 1;
        hdata = rsp_data;
        hid   = rsp_id;
      end
    end
  end

  // Drive one request and wait for its grant; with may_drop it gives up early.
  task automatic send(input int i, input int x, input int y, input bit ope, input bit sign,
                      input bit may_drop, output bit ok);
    int lim;
    lim = may_drop ? $urandom_range(1, 4) : 200;
    ok = 0;
    v[i] = 1'b1; a[i] = OP_W'(x); b[i] = OP_W'(y); e[i] = ope; s[i] = sign;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    v[i] = 1'b0;
    if (ok) acc.push_back(i);
    if (!ok && !may_drop) begin
      checks++; failures++;
      $display("FAIL grant_timeout: req%0d never granted", i);
    end
  endtask

  task automatic directed(input int i, input int x, input int y, input bit ope, input bit sign,
                          input logic [RES_W-1:0] exp_data);
    bit ok;
    int lat;
    send(i, x, y, ope, sign, 0, ok);
    chk("dir_accept", ok, 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    chk("dir_latency", lat, 2);
    chk("dir_data", rsp_data, exp_data);
    chk("dir_id", rsp_id, i);
    @(posedge clk); #1;
  endtask

  task automatic rnd_req(input int i);
    bit ok;
    int gap;
    repeat (40) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      send(i, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ok);
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (busy && c < 50);
    chk("drain_idle", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit rnd_on;
  bit ok0, ok1;
  int c;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; a[i] = '0; b[i] = '0; e[i] = 1'b0; s[i] = 1'b0;
    end
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    v[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_ops_done_sat", ops_done2, 0);
    v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    directed(0, 7, 9, 0, 0, 20'h00010);
    @(negedge clk);
    chk("ops_done_first", ops_done, 1);
    @(posedge clk); #1;
    directed(0, 3, 5, 0, 1, 20'hFFFFE);
    directed(0, 15, 15, 1, 0, 20'h78000);
    directed(0, 12, 2, 1, 1, 20'h00003);
    @(negedge clk);
    chk("ops_done_four", ops_done, 4);
    chk("sat_stays_3", ops_done2, 3);
    @(posedge clk); #1;

    // Contention: both requesters continuously valid; ptr is 1 after req0 ops.
    acc.delete();
    fork
      begin repeat (6) send(0, $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 0, ok0); end
      begin repeat (6) send(1, $urandom_range(0, 15), $urandom_range(0, 15), 0, 1, 0, ok1); end
    join
    chk("contend_count", acc.size(), 12);
    for (int k = 0; k < acc.size(); k++) chk("contend_alternate", acc[k], (k + 1) % 2);
    wait_idle();

    // Backpressure: result held, nothing granted while req1 waits.
    rsp_ready = 1'b0;
    send(0, 5, 6, 0, 0, 0, ok0);
    fork
      send(1, 2, 3, 1, 0, 0, ok1);
      begin
        c = 0;
        while (!rsp_valid && c < 20) begin @(negedge clk); c++; end
        repeat (10) begin
          chk("bp_valid", rsp_valid, 1);
          chk("bp_busy", busy, 1);
          chk("bp_no_ready", req_ready, 0);
          chk("bp_data", rsp_data, 11);
          chk("bp_id", rsp_id, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    chk("bp_req1_granted", ok1, 1);
    wait_idle();

    // Randomised traffic with random consumer stalls.
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        fork
          rnd_req(0);
          rnd_req(1);
        join
        rnd_on = 0;
      end
    join
    rsp_ready = 1'b1;
    wait_idle();
    chk("sb_empty", sbq.size(), 0);
    chk("sat_after_random", ops_done2, 3);

    // Reset while the op is in EXEC.
    send(0, 1, 1, 0, 0, 0, ok0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    chk("midrst_ops_done", ops_done, 0);
    chk("midrst_ops_done_sat", ops_done2, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    directed(1, 12, 2, 1, 1, 20'h00003);

    // After a fresh reset requester 0 wins when both ask.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc.delete();
    fork
      send(0, 4, 4, 0, 0, 0, ok0);
      send(1, 4, 4, 0, 1, 0, ok1);
    join
    chk("prio_count", acc.size(), 2);
    if (acc.size() == 2) begin
      chk("prio_first", acc[0], 0);
      chk("prio_second", acc[1], 1);
    end
    wait_idle();
    chk("final_sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
